// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, FSM states and iterative-engine kinds.
// Also used by the ALU control block so that both sides share one set of op codes.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_SQRT = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_SQRT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    KIND_MUL,
    KIND_DIV,
    KIND_SQRT
  } iter_kind_e;

endpackage

// File: rtl/alu_iter_engine.sv
// Iterative datapath shared by shift-add multiply, restoring remainder and digit-by-digit sqrt.
// 'value' is the result produced by the step currently being taken, valid when step && last.
module alu_iter_engine
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  iter_kind_e       kind,
  input  logic             step,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             last,
  output logic [W-1:0]     value
);

  iter_kind_e         kind_q, kind_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [W-1:0]       x_q, x_d;
  logic [W-1:0]       y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [W-1:0]       mul_sum;
  logic [W:0]         div_tmp;
  logic               div_ge;
  logic [W+1:0]       sq_br;
  logic [W+1:0]       sq_trial;
  logic               sq_ge;

  // acc holds product / partial remainder; x is the operand being consumed; y is mcand/divisor/root
  always_comb begin
    mul_sum  = acc_q + (x_q[0] ? y_q : '0);
    div_tmp  = {acc_q, x_q[W-1]};
    div_ge   = (div_tmp >= {1'b0, y_q});
    sq_br    = {acc_q, x_q[W-1:W-2]};
    sq_trial = {y_q, 2'b01};
    sq_ge    = (sq_br >= sq_trial);
  end

  always_comb begin
    kind_d = kind_q;
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    cnt_d  = cnt_q;
    value  = '0;

    case (kind_q)
      KIND_MUL:  value = mul_sum;
      KIND_DIV:  value = div_ge ? (div_tmp[W-1:0] - y_q) : div_tmp[W-1:0];
      KIND_SQRT: value = {y_q[W-2:0], sq_ge};
      default:   value = '0;
    endcase

    if (load) begin
      kind_d = kind;
      acc_d  = '0;
      cnt_d  = (kind == KIND_SQRT) ? CNT_W'(W / 2) : CNT_W'(W);
      case (kind)
        KIND_MUL: begin
          x_d = b;
          y_d = a;
        end
        KIND_DIV: begin
          x_d = a;
          y_d = b;
        end
        default: begin
          x_d = a;
          y_d = '0;
        end
      endcase
    end else if (step) begin
      cnt_d = cnt_q - CNT_W'(1);
      case (kind_q)
        KIND_MUL: begin
          acc_d = mul_sum;
          x_d   = {1'b0, x_q[W-1:1]};
          y_d   = {y_q[W-2:0], 1'b0};
        end
        KIND_DIV: begin
          acc_d = value;
          x_d   = {x_q[W-2:0], 1'b0};
        end
        default: begin
          acc_d = sq_ge ? (sq_br[W-1:0] - sq_trial[W-1:0]) : sq_br[W-1:0];
          x_d   = {x_q[W-3:0], 2'b00};
          y_d   = value;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q <= KIND_MUL;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
    end else begin
      kind_q <= kind_d;
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with single-cycle ops and iterative mul/mod/sqrt behind a start/busy/done handshake.
// Define ALU_OVF_EN to register signed add/sub overflow; otherwise the overflow pin is tied low.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [4:0]    shamt,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          zero,
  output logic          div_zero,
  output logic          overflow
);

  state_e        state_q, state_d;
  logic [W-1:0]  result_q, result_d;
  logic          zero_q, zero_d;
  logic          div_zero_q, div_zero_d;
  logic          done_q, done_d;

  logic          res_load;
  logic [W-1:0]  res_val;
  logic          res_dz;
  logic          idle_like;

  logic          eng_load;
  logic          eng_step;
  iter_kind_e    eng_kind;
  logic          eng_last;
  logic [W-1:0]  eng_value;

  logic [W-1:0]  add_res;
  logic [W-1:0]  sub_res;
  logic [W-1:0]  single_res;

  assign add_res   = a + b;
  assign sub_res   = a - b;
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);

  always_comb begin
    single_res = '0;
    case (op)
      OP_ADD:  single_res = add_res;
      OP_SUB:  single_res = sub_res;
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_SLT:  single_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  single_res = b << shamt;
      default: single_res = '0;
    endcase
  end

  // DONE accepts a new start exactly like IDLE so the control FSM never loses a cycle
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    res_load = 1'b0;
    res_val  = '0;
    res_dz   = 1'b0;
    eng_load = 1'b0;
    eng_step = 1'b0;
    eng_kind = KIND_MUL;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          case (op)
            OP_MUL: begin
              eng_load = 1'b1;
              eng_kind = KIND_MUL;
              state_d  = ST_MUL;
            end
            OP_MOD: begin
              if (b == '0) begin
                res_load = 1'b1;
                res_val  = a;
                res_dz   = 1'b1;
                done_d   = 1'b1;
              end else begin
                eng_load = 1'b1;
                eng_kind = KIND_DIV;
                state_d  = ST_DIV;
              end
            end
            OP_SQRT: begin
              eng_load = 1'b1;
              eng_kind = KIND_SQRT;
              state_d  = ST_SQRT;
            end
            default: begin
              res_load = 1'b1;
              res_val  = single_res;
              done_d   = 1'b1;
            end
          endcase
        end
      end
      ST_MUL, ST_DIV, ST_SQRT: begin
        eng_step = 1'b1;
        if (eng_last) begin
          res_load = 1'b1;
          res_val  = eng_value;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    result_d   = res_load ? res_val : result_q;
    zero_d     = res_load ? (res_val == '0) : zero_q;
    div_zero_d = res_load ? res_dz : div_zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  alu_iter_engine #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (eng_load),
    .kind  (eng_kind),
    .step  (eng_step),
    .a     (a),
    .b     (b),
    .last  (eng_last),
    .value (eng_value)
  );

`ifdef ALU_OVF_EN
  logic ovf_q, ovf_d;
  logic single_ovf;

  // Overflow when operands (after sub negation) share a sign that the result does not
  always_comb begin
    single_ovf = 1'b0;
    case (op)
      OP_ADD:  single_ovf = (a[W-1] == b[W-1]) && (add_res[W-1] != a[W-1]);
      OP_SUB:  single_ovf = (a[W-1] != b[W-1]) && (sub_res[W-1] != a[W-1]);
      default: single_ovf = 1'b0;
    endcase
    ovf_d = res_load ? (idle_like && single_ovf) : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy     = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_SQRT);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign div_zero = div_zero_q;

endmodule
